// File: rtl/sm_dm_arbiter_if.sv
// sm_dm_arbiter_if
//   Bundles the two requester ports (m0_*, m1_*) and the shared data-memory
//   port (s_*) of the arbiter.
//
//   Handshake: a requester raises mN_valid and holds mN_addr/mN_we/mN_wd
//   stable until it sees a one-cycle mN_ready pulse. mN_rd and mN_err are
//   meaningful only while mN_ready=1. Toward memory, s_valid requests a
//   transfer and s_ready=1 completes it in that same cycle.
//
//   Modports:
//     slave  - arbiter view: requester fields in, completions out,
//              shared memory request out, memory response in.
//     master - environment view: the exact opposite.
interface sm_dm_arbiter_if;
   logic [31:0] m0_addr, m1_addr;
   logic        m0_we, m1_we;
   logic [31:0] m0_wd, m1_wd;
   logic        m0_valid, m1_valid;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rd, m1_rd;
   logic        m0_err, m1_err;

   logic [31:0] s_addr;
   logic        s_we;
   logic [31:0] s_wd;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_rd;

   modport slave (
      input  m0_addr, m1_addr, m0_we, m1_we, m0_wd, m1_wd, m0_valid, m1_valid,
      output m0_ready, m1_ready, m0_rd, m1_rd, m0_err, m1_err,
      output s_addr, s_we, s_wd, s_valid,
      input  s_ready, s_rd
   );

   modport master (
      output m0_addr, m1_addr, m0_we, m1_we, m0_wd, m1_wd, m0_valid, m1_valid,
      input  m0_ready, m1_ready, m0_rd, m1_rd, m0_err, m1_err,
      input  s_addr, s_we, s_wd, s_valid,
      output s_ready, s_rd
   );
endinterface

// File: rtl/sm_dm_arbiter.sv
// sm_dm_arbiter
//   Two-requester round-robin arbiter in front of a single shared data
//   memory, with a per-transfer timeout.
//
//   Ports:
//     clk         - clock, all state updates on rising edge
//     rst_n       - asynchronous active-low reset
//     bus         - sm_dm_arbiter_if.slave (requesters m0/m1 + shared memory)
//     o_dbg_state - current FSM state (0 = IDLE, 1 = BUSY)
//
//   Parameters:
//     TIMEOUT - BUSY cycles allowed before the transfer is aborted (1..2^TO_W-1)
//     TO_W    - width of the timeout counter
module sm_dm_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   sm_dm_arbiter_if.slave    bus,
   output logic              o_dbg_state
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TCNT_MAX = '1;

   state_t          r_state;
   logic            r_owner;
   logic            r_last;
   logic [TO_W-1:0] r_tcnt;

   logic w_busy;
   logic w_own_valid;
   logic w_done;
   logic w_timeout;
   logic w_finish;

   assign w_busy      = (r_state == BUSY);
   assign w_own_valid = r_owner ? bus.m1_valid : bus.m0_valid;
   // s_ready wins over the timeout when both land in the same cycle.
   assign w_done      = w_busy & w_own_valid & bus.s_ready;
   assign w_timeout   = w_busy & w_own_valid & ~bus.s_ready & (r_tcnt == TO_LAST);
   assign w_finish    = w_done | w_timeout;

   // Request fields are muxed unconditionally; s_valid alone qualifies them.
   assign bus.s_addr  = r_owner ? bus.m1_addr : bus.m0_addr;
   assign bus.s_we    = r_owner ? bus.m1_we   : bus.m0_we;
   assign bus.s_wd    = r_owner ? bus.m1_wd   : bus.m0_wd;
   assign bus.s_valid = w_busy & w_own_valid & ~w_timeout;

   assign bus.m0_ready = w_finish  & ~r_owner;
   assign bus.m1_ready = w_finish  &  r_owner;
   assign bus.m0_err   = w_timeout & ~r_owner;
   assign bus.m1_err   = w_timeout &  r_owner;
   assign bus.m0_rd    = (w_done & ~r_owner) ? bus.s_rd : '0;
   assign bus.m1_rd    = (w_done &  r_owner) ? bus.s_rd : '0;

   assign o_dbg_state  = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         // last=1 makes m0 the winner of the first simultaneous request.
         r_last  <= 1'b1;
         r_tcnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.m0_valid | bus.m1_valid) begin
                  r_state <= BUSY;
                  r_tcnt  <= '0;
                  if (bus.m0_valid & bus.m1_valid)
                     r_owner <= ~r_last;
                  else
                     r_owner <= bus.m1_valid;
               end
            end
            BUSY: begin
               if (!w_own_valid) begin
                  // Owner withdrew its request: drop it without touching last.
                  r_state <= IDLE;
                  r_tcnt  <= '0;
               end else if (w_finish) begin
                  r_state <= IDLE;
                  r_last  <= r_owner;
                  r_tcnt  <= '0;
               end else if (r_tcnt != TCNT_MAX) begin
                  r_tcnt  <= r_tcnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sm_dm_arbiter.sv
// tb_sm_dm_arbiter
//   Self-checking bench for sm_dm_arbiter (TIMEOUT=4). Every completion the
//   bench expects is pushed to exp_q as {id, err, rd} when the request is
//   driven; the monitor pops and compares on each mN_ready pulse.
module tb_sm_dm_arbiter;

   logic clk;
   logic rst_n;
   logic dbg_state;

   sm_dm_arbiter_if bus ();

   sm_dm_arbiter #(.TIMEOUT(4), .TO_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [33:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        spacing_en = 1'b0;
   int          last_rdy[2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_exp(input logic id, input logic err, input logic [31:0] rd);
      exp_q.push_back({id, err, rd});
   endtask

   logic        mon_id;
   logic [33:0] mon_obs;
   logic [33:0] mon_exp;

   always @(negedge clk) begin
      if (rst_n) begin
         check("one_ready", 64'(bus.m0_ready & bus.m1_ready), 64'(0));
         if (!bus.m0_ready) check("m0_quiet", 64'({bus.m0_err, bus.m0_rd}), 64'(0));
         if (!bus.m1_ready) check("m1_quiet", 64'({bus.m1_err, bus.m1_rd}), 64'(0));
         if (bus.m0_ready | bus.m1_ready) begin
            mon_id  = bus.m1_ready;
            mon_obs = mon_id ? {1'b1, bus.m1_err, bus.m1_rd} : {1'b0, bus.m0_err, bus.m0_rd};
            check("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               mon_exp = exp_q.pop_front();
               check("sb_result", 64'(mon_obs), 64'(mon_exp));
            end
            if (spacing_en) begin
               if (last_rdy[mon_id] >= 0)
                  check("ready_spacing", 64'(cyc - last_rdy[mon_id]), 64'(4));
               last_rdy[mon_id] = cyc;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.m0_valid = v; bus.m0_we = we; bus.m0_addr = a; bus.m0_wd = d;
   endtask

   task automatic set_m1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.m1_valid = v; bus.m1_we = we; bus.m1_addr = a; bus.m1_wd = d;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      bus.s_ready = 1'b0;
      bus.s_rd    = 32'h0;
      last_rdy[0] = -1;
      last_rdy[1] = -1;

      // Reset state
      step();
      @(negedge clk);
      check("rst_state",   64'(dbg_state), 64'(0));
      check("rst_s_valid", 64'(bus.s_valid), 64'(0));
      check("rst_ready",   64'({bus.m0_ready, bus.m1_ready}), 64'(0));
      check("rst_err_rd",  64'({bus.m0_err, bus.m1_err, bus.m0_rd}), 64'(0));
      step();
      rst_n = 1'b1;

      // Timeout: m1 write, s_ready held low, abort in 4th BUSY cycle
      set_m1(1'b1, 1'b1, 32'h40, 32'h1234_5678);
      bus.s_ready = 1'b0;
      bus.s_rd    = 32'hBAD0_BAD0;
      push_exp(1'b1, 1'b1, 32'h0);
      @(negedge clk);
      check("to_idle_sv", 64'(bus.s_valid), 64'(0));
      for (int i = 1; i <= 4; i++) begin
         step();
         @(negedge clk);
         check("to_state", 64'(dbg_state), 64'(1));
         check("to_s_valid", 64'(bus.s_valid), 64'(i < 4));
         check("to_m1_ready", 64'(bus.m1_ready), 64'(i == 4));
      end
      step();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("to_back_idle", 64'(dbg_state), 64'(0));

      // Single read on m0: ready one cycle after the request is seen in IDLE
      step();
      set_m0(1'b1, 1'b0, 32'h10, 32'h0);
      bus.s_ready = 1'b1;
      bus.s_rd    = 32'hDEAD_BEEF;
      push_exp(1'b0, 1'b0, 32'hDEAD_BEEF);
      @(negedge clk);
      check("rd_k_ready", 64'(bus.m0_ready), 64'(0));
      step();
      @(negedge clk);
      check("rd_s_addr",  64'(bus.s_addr), 64'(32'h10));
      check("rd_s_valid", 64'(bus.s_valid), 64'(1));
      check("rd_k1_ready", 64'(bus.m0_ready), 64'(1));
      check("rd_m1_zero", 64'({bus.m1_ready, bus.m1_err, bus.m1_rd}), 64'(0));
      step();
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      bus.s_ready = 1'b0;

      // Wait states: m1 write (wins, last=m0) with m0 pending; 3 wait cycles
      step();
      set_m1(1'b1, 1'b1, 32'h20, 32'h5A);
      set_m0(1'b1, 1'b0, 32'h30, 32'h0);
      bus.s_rd = 32'h1111_2222;
      push_exp(1'b1, 1'b0, 32'h1111_2222);
      push_exp(1'b0, 1'b0, 32'h1111_2222);
      for (int i = 1; i <= 4; i++) begin
         step();
         if (i == 4) bus.s_ready = 1'b1;
         @(negedge clk);
         check("ws_s_req", 64'({bus.s_valid, bus.s_we, bus.s_addr, bus.s_wd[7:0]}),
               64'({1'b1, 1'b1, 32'h20, 8'h5A}));
         check("ws_m1_ready", 64'(bus.m1_ready), 64'(i == 4));
      end
      step();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      // s_ready is high here but the arbiter is IDLE: nothing may complete.
      check("ws_idle_state", 64'(dbg_state), 64'(0));
      check("ws_idle_ready", 64'(bus.m0_ready), 64'(0));
      step();
      @(negedge clk);
      check("ws_m0_addr", 64'(bus.s_addr), 64'(32'h30));
      step();
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      bus.s_ready = 1'b0;

      // Owner withdraws mid-BUSY: no completion, last stays m0
      step();
      set_m1(1'b1, 1'b0, 32'h50, 32'h0);
      step();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("pv_s_valid", 64'(bus.s_valid), 64'(0));
      check("pv_ready", 64'(bus.m1_ready), 64'(0));
      step();
      @(negedge clk);
      check("pv_idle", 64'(dbg_state), 64'(0));
      set_m0(1'b1, 1'b0, 32'h60, 32'h0);
      set_m1(1'b1, 1'b0, 32'h70, 32'h0);
      bus.s_ready = 1'b1;
      bus.s_rd    = 32'h0BAD_F00D;
      push_exp(1'b1, 1'b0, 32'h0BAD_F00D);
      push_exp(1'b0, 1'b0, 32'h0BAD_F00D);
      step();
      step();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      bus.s_ready = 1'b0;

      // Reset during BUSY, then contention with both requesters always valid
      step();
      set_m1(1'b1, 1'b1, 32'h80, 32'h99);
      step();
      @(negedge clk);
      check("mr_busy_sv", 64'(bus.s_valid), 64'(1));
      #1;
      rst_n = 1'b0;
      #1;
      check("mr_state", 64'(dbg_state), 64'(0));
      check("mr_outputs", 64'({bus.s_valid, bus.m1_ready, bus.m1_err, bus.m1_rd}), 64'(0));
      set_m0(1'b1, 1'b0, 32'h100, 32'h0);
      set_m1(1'b1, 1'b0, 32'h200, 32'h0);
      bus.s_ready = 1'b1;
      bus.s_rd    = 32'h600D_F00D;
      for (int g = 0; g < 6; g++) push_exp(1'(g % 2), 1'b0, 32'h600D_F00D);
      spacing_en = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) step();
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      spacing_en = 1'b0;
      step();
      step();

      check("sb_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
